token_issue_queue: RTL and testbench
====================================

Name: token_issue_queue

Overview:
Upstream stage of the token distribution path. Issues sequential 4-bit token numbers to arriving customers and buffers pending tokens in a 7-entry FIFO, one per downstream token slot. Releases tokens in order when a service point requests the next one. The 4-bit value it releases is what the downstream token stage routes to its token1..token7 outputs.

Parameters:
- DEPTH, 7: pending-token capacity; must be ≤ 2^TW − 1.
- TW, 4: token number width.
- CW, 3: occupancy width; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; reset = 0 clears all state immediately.
- issue_req  input  1  customer requests a token; sampled each rising edge.
- serve_req  input  1  service point requests the next pending token; sampled each rising edge.
- issue_ack  output  1  one-cycle pulse: the issue request was accepted.
- issue_reject  output  1  one-cycle pulse: the issue request was refused because the queue is full.
- issue_token  output  TW  number assigned to the last accepted issue; holds until the next accept.
- serve_valid  output  1  one-cycle pulse: serve_token carries a newly released token.
- serve_token  output  TW  value to the downstream token stage; holds the last served token.
- count  output  CW  number of pending tokens, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset values (reset = 0, asynchronous):
  - count = 0, empty = 1, full = 0.
  - issue_ack = 0, issue_reject = 0, serve_valid = 0.
  - issue_token = 0, serve_token = 0.
  - Write and read pointers = 0.
  - next_num = 1.
- Token numbering:
  - Token 0 is reserved and means "no token"; it is never issued.
  - next_num increments on each accepted issue and wraps 15 → 1.
- Storage: circular buffer of DEPTH × TW registers. Write and read pointers run 0..DEPTH−1 and wrap DEPTH−1 → 0.
- Issue acceptance: accepted at edge k when issue_req = 1 and either full = 0, or full = 1 with a serve accepted in the same edge.
  - On accept: store next_num at the write pointer and advance the pointer.
  - In cycle k+1: issue_token = that number and issue_ack = 1.
- Issue refusal: issue_req = 1 that is not accepted gives issue_reject = 1 in cycle k+1. The queue, next_num and issue_token are unchanged.
- Serve acceptance: accepted at edge k when serve_req = 1 and empty = 0.
  - On accept: read the head entry and advance the read pointer.
  - In cycle k+1: serve_token = that entry and serve_valid = 1.
- Serve on empty: serve_req = 1 while empty = 1 is ignored. serve_valid stays 0 and serve_token holds its value. There is no bypass: a simultaneous issue into an empty queue is stored, not served.
- Simultaneous accepted issue and serve: count is unchanged. Both pulses assert in the next cycle.
- count update: +1 on issue only, −1 on serve only. full and empty are derived from the registered count.
- Latency: 1 cycle from request edge to ack/valid. A sustained request gives back-to-back accepts, one per cycle.
- Ordering: tokens are served strictly in issue order, including across pointer wrap and number wrap.
- Reset mid-operation: pending tokens are discarded and numbering restarts at 1. Pulses in flight are cleared.
- issue_ack and issue_reject are never high together.

Test Plan:
1. Reset sequence: hold reset = 0 for 3 cycles, then release → count = 0, empty = 1, all pulses 0, serve_token = 0. The first issue_req gives issue_token = 1 with issue_ack one cycle later.
2. Fill to full: issue_req high for 8 cycles, serve_req = 0 → tokens 1..7 acked on consecutive cycles, full = 1 after the 7th. The 8th request gives issue_reject = 1 and count stays 7.
3. Drain: serve_req high for 8 cycles on the full queue → serve_token = 1,2,…,7 with serve_valid each cycle. The 8th request gives serve_valid = 0, serve_token holds 7, empty = 1.
4. Simultaneous issue and serve at full (queue holds 1..7): one cycle of both requests → serve_token = 1, issue_token = 8, count stays 7, no reject.
5. Number wrap: issue and serve 15 tokens one at a time, then issue once more → the 16th issued token is 1 (never 0), and serve order stays FIFO across pointer wrap.
6. Reset mid-operation: queue holds 3 tokens, assert reset asynchronously between edges → outputs clear immediately. After release, the next issue is token 1 and the next serve on an empty queue produces no serve_valid.

Source files
------------

// File: rtl/token_issue_queue_if.sv
// token_issue_queue_if: issue/serve handshake and status bundle for the token issue queue.
interface token_issue_queue_if #(
  parameter int TW = 4,
  parameter int CW = 3
);
  logic          issue_req;
  logic          serve_req;
  logic          issue_ack;
  logic          issue_reject;
  logic [TW-1:0] issue_token;
  logic          serve_valid;
  logic [TW-1:0] serve_token;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  modport master (
    output issue_req, serve_req,
    input  issue_ack, issue_reject, issue_token, serve_valid, serve_token, count, full, empty
  );
  modport slave (
    input  issue_req, serve_req,
    output issue_ack, issue_reject, issue_token, serve_valid, serve_token, count, full, empty
  );
endinterface

// File: rtl/token_issue_queue.sv
// token_issue_queue: issues sequential nonzero token numbers and releases them in FIFO order.
module token_issue_queue #(
  parameter int DEPTH = 7,
  parameter int TW    = 4,
  parameter int CW    = 3
) (
  input logic                 clk,
  input logic                 reset,
  token_issue_queue_if.slave  q
);
  logic [TW-1:0] mem [0:DEPTH-1];
  logic [CW-1:0] wp, rp, count;
  logic [TW-1:0] next_num, issue_token, serve_token;
  logic          issue_ack, issue_reject, serve_valid;
  logic          full, empty, do_serve, do_issue;
  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign do_serve = q.serve_req && !empty;
  // a serve in the same edge frees a slot, so a full queue can still accept
  assign do_issue = q.issue_req && (!full || do_serve);
  always_ff @(posedge clk)
    if (do_issue) mem[wp] <= next_num;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      next_num     <= TW'(1);
      issue_token  <= '0;
      serve_token  <= '0;
      issue_ack    <= 1'b0;
      issue_reject <= 1'b0;
      serve_valid  <= 1'b0;
    end else begin
      issue_ack    <= do_issue;
      issue_reject <= q.issue_req && !do_issue;
      serve_valid  <= do_serve;
      if (do_issue) begin
        issue_token <= next_num;
        wp          <= (wp == CW'(DEPTH - 1)) ? '0 : wp + 1'b1;
        // token 0 means "no token", so numbering skips it on wrap
        next_num    <= (next_num == '1) ? TW'(1) : next_num + 1'b1;
      end
      if (do_serve) begin
        serve_token <= mem[rp];
        rp          <= (rp == CW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      end
      count <= (do_issue && !do_serve) ? count + 1'b1 :
               (do_serve && !do_issue) ? count - 1'b1 : count;
    end
  assign q.issue_ack    = issue_ack;
  assign q.issue_reject = issue_reject;
  assign q.issue_token  = issue_token;
  assign q.serve_valid  = serve_valid;
  assign q.serve_token  = serve_token;
  assign q.count        = count;
  assign q.full         = full;
  assign q.empty        = empty;
endmodule

// File: tb/tb_token_issue_queue.sv
// tb_token_issue_queue: directed and random stimulus against a queue-based model of the token issuer.
module tb_token_issue_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  token_issue_queue_if #(.TW(4), .CW(3)) bus ();
  token_issue_queue #(.DEPTH(7), .TW(4), .CW(3)) dut (.clk(clk), .reset(reset), .q(bus));
  int total = 0;
  int bad = 0;
  int pend[$];
  int next_num = 1;
  int e_ack, e_rej, e_it, e_sv, e_st;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    next_num = 1;
    e_ack = 0; e_rej = 0; e_it = 0; e_sv = 0; e_st = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".issue_ack"},    32'(bus.issue_ack),    32'(e_ack));
    chk({tag, ".issue_reject"}, 32'(bus.issue_reject), 32'(e_rej));
    chk({tag, ".issue_token"},  32'(bus.issue_token),  32'(e_it));
    chk({tag, ".serve_valid"},  32'(bus.serve_valid),  32'(e_sv));
    chk({tag, ".serve_token"},  32'(bus.serve_token),  32'(e_st));
    chk({tag, ".count"},        32'(bus.count),        32'(pend.size()));
    chk({tag, ".full"},         32'(bus.full),         32'(pend.size() == 7));
    chk({tag, ".empty"},        32'(bus.empty),        32'(pend.size() == 0));
  endtask
  task automatic step(input string tag, input logic ir, input logic sr);
    bit ds, di;
    bus.issue_req = ir;
    bus.serve_req = sr;
    @(posedge clk);
    ds = sr && pend.size() > 0;
    di = ir && (pend.size() < 7 || ds);
    e_ack = int'(di);
    e_rej = int'(ir && !di);
    e_sv  = int'(ds);
    if (ds) e_st = pend.pop_front();
    if (di) begin
      pend.push_back(next_num);
      e_it = next_num;
      next_num = (next_num == 15) ? 1 : next_num + 1;
    end
    #1 check_all(tag);
  endtask
  initial begin
    bus.issue_req = 1'b0;
    bus.serve_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    reset = 1'b1;
    step("first_issue", 1'b1, 1'b0);
    step("first_serve", 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step("refill", 1'b1, 1'b0);
    step("both_at_full", 1'b1, 1'b1);
    step("serve_empty_issue", 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1);
    step("issue_into_empty_with_serve", 1'b1, 1'b1);
    step("serve_after", 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step("wrap_issue", 1'b1, 1'b0);
      step("wrap_serve", 1'b0, 1'b1);
    end
    step("wrap_last", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("pre_reset", 1'b1, 1'b0);
    #3 reset = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    @(posedge clk);
    #1 reset = 1'b1;
    step("post_reset_serve", 1'b0, 1'b1);
    step("post_reset_issue", 1'b1, 1'b0);
    for (int i = 0; i < 400; i++)
      step("random", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45));
    for (int i = 0; i < 200; i++)
      step("random_heavy", 1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 80));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
